// File: rtl/study_judge.sv
// study_judge: scores committed study-mode hits against the current goal note.
// Accumulates points and a saturating hit streak, pulses o_advance once per
// judged hit, and freezes a letter grade after the last note of the track.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_en                study mode active; low returns the block to IDLE
//   i_hit_valid         one-cycle pulse when the player commits a note
//   i_play_*            played octave / note / length
//   i_goal_*            expected octave / note / length at i_goal_idx
//   i_goal_idx, i_track current goal index, index of last note in the song
//   o_advance           one-cycle pulse requesting the next goal note
//   o_score             accumulated points
//   o_streak            consecutive non-miss judgements, saturating at 63
//   o_last_result       00 none, 01 miss, 10 partial, 11 exact
//   o_done              song finished, outputs frozen
//   o_grade             4=S, 3=A, 2=B, 1=C, 0=D/none
module study_judge #(
    parameter int unsigned OCTAVE_BITS   = 3,
    parameter int unsigned NOTE_BITS     = 3,
    parameter int unsigned LENGTH_BITS   = 3,
    parameter int unsigned SONG_CNT_BITS = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic                     i_hit_valid,
    input  logic [OCTAVE_BITS-1:0]   i_play_octave,
    input  logic [NOTE_BITS-1:0]     i_play_note,
    input  logic [LENGTH_BITS-1:0]   i_play_length,
    input  logic [OCTAVE_BITS-1:0]   i_goal_octave,
    input  logic [NOTE_BITS-1:0]     i_goal_note,
    input  logic [LENGTH_BITS-1:0]   i_goal_length,
    input  logic [SONG_CNT_BITS-1:0] i_goal_idx,
    input  logic [SONG_CNT_BITS-1:0] i_track,
    output logic                     o_advance,
    output logic [7:0]               o_score,
    output logic [5:0]               o_streak,
    output logic [1:0]               o_last_result,
    output logic                     o_done,
    output logic [2:0]               o_grade
);

    localparam int unsigned CMP_W = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_JUDGE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [OCTAVE_BITS-1:0] r_play_octave;
    logic [NOTE_BITS-1:0]   r_play_note;
    logic [LENGTH_BITS-1:0] r_play_length;
    logic [OCTAVE_BITS-1:0] r_goal_octave;
    logic [NOTE_BITS-1:0]   r_goal_note;
    logic [LENGTH_BITS-1:0] r_goal_length;
    logic                   r_is_last;

    logic             w_exact;
    logic             w_partial;
    logic [7:0]       w_new_score;
    logic [5:0]       w_new_streak;
    logic [1:0]       w_result;
    logic [7:0]       w_max;
    logic [CMP_W-1:0] w_s10;
    logic [CMP_W-1:0] w_m10;
    logic [CMP_W-1:0] w_s4;
    logic [CMP_W-1:0] w_m3;
    logic [2:0]       w_grade;

    // Judgement of the captured hit; rests follow the same field comparison.
    always_comb begin
        w_exact   = (r_play_octave == r_goal_octave) && (r_play_note == r_goal_note)
                 && (r_play_length == r_goal_length);
        w_partial = (r_play_octave == r_goal_octave) && (r_play_note == r_goal_note)
                 && (r_play_length != r_goal_length);
        if (w_exact) begin
            w_new_score  = o_score + 8'd2;
            w_result     = 2'b11;
        end else if (w_partial) begin
            w_new_score  = o_score + 8'd1;
            w_result     = 2'b10;
        end else begin
            w_new_score  = o_score;
            w_result     = 2'b01;
        end
        if (w_exact || w_partial) begin
            w_new_streak = (o_streak == 6'd63) ? 6'd63 : o_streak + 6'd1;
        end else begin
            w_new_streak = 6'd0;
        end
    end

    // Grade thresholds on the post-judgement score, 10-bit intermediates.
    always_comb begin
        w_max = 8'((CMP_W'(i_track) + CMP_W'(1)) << 1);
        w_s10 = CMP_W'(w_new_score);
        w_m10 = CMP_W'(w_max);
        w_s4  = w_s10 << 2;
        w_m3  = CMP_W'(w_m10 * CMP_W'(3));
        if (w_new_score == w_max)         w_grade = 3'd4;
        else if (w_s4 >= w_m3)            w_grade = 3'd3;
        else if ((w_s10 << 1) >= w_m10)   w_grade = 3'd2;
        else if (w_s4 >= w_m10)           w_grade = 3'd1;
        else                              w_grade = 3'd0;
    end

    // Control FSM with registered outputs; en low overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_play_octave <= '0;
            r_play_note   <= '0;
            r_play_length <= '0;
            r_goal_octave <= '0;
            r_goal_note   <= '0;
            r_goal_length <= '0;
            r_is_last     <= 1'b0;
            o_advance     <= 1'b0;
            o_score       <= '0;
            o_streak      <= '0;
            o_last_result <= '0;
            o_done        <= 1'b0;
            o_grade       <= '0;
        end else if (!i_en) begin
            r_state       <= S_IDLE;
            r_play_octave <= '0;
            r_play_note   <= '0;
            r_play_length <= '0;
            r_goal_octave <= '0;
            r_goal_note   <= '0;
            r_goal_length <= '0;
            r_is_last     <= 1'b0;
            o_advance     <= 1'b0;
            o_score       <= '0;
            o_streak      <= '0;
            o_last_result <= '0;
            o_done        <= 1'b0;
            o_grade       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (i_hit_valid) begin
                        r_play_octave <= i_play_octave;
                        r_play_note   <= i_play_note;
                        r_play_length <= i_play_length;
                        r_goal_octave <= i_goal_octave;
                        r_goal_note   <= i_goal_note;
                        r_goal_length <= i_goal_length;
                        r_is_last     <= (i_goal_idx == i_track);
                        o_advance     <= 1'b1;
                        r_state       <= S_JUDGE;
                    end
                end
                S_JUDGE: begin
                    o_advance     <= 1'b0;
                    o_score       <= w_new_score;
                    o_streak      <= w_new_streak;
                    o_last_result <= w_result;
                    if (r_is_last) begin
                        o_done  <= 1'b1;
                        o_grade <= w_grade;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_ARMED;
                    end
                end
                default: begin
                    o_advance <= 1'b0;
                end
            endcase
        end
    end

endmodule
